// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty ramp controller.
package pwm_pkg;

  localparam int DUTY_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating ramp step: moves current toward target by step, never past it.
module pwm_ramp_step
  import pwm_pkg::*;
#(
  parameter int DUTY_CYCLE_WIDTH = DUTY_W_DEFAULT
) (
  input  logic [DUTY_CYCLE_WIDTH-1:0] current_i,
  input  logic [DUTY_CYCLE_WIDTH-1:0] target_i,
  input  logic [DUTY_CYCLE_WIDTH-1:0] step_i,
  output logic [DUTY_CYCLE_WIDTH-1:0] next_o
);

  localparam int W = DUTY_CYCLE_WIDTH;

  // One extra bit so the sum cannot wrap past full scale and the difference stays signed.
  function automatic logic [W-1:0] sat_step(input logic [W-1:0] cur,
                                            input logic [W-1:0] tgt,
                                            input logic [W-1:0] stp);
    logic        [W:0] up_sum;
    logic signed [W:0] dn_diff;
    if (stp == '0) begin
      return tgt;
    end
    if (tgt > cur) begin
      up_sum = {1'b0, cur} + {1'b0, stp};
      return (up_sum >= {1'b0, tgt}) ? tgt : up_sum[W-1:0];
    end
    dn_diff = $signed({1'b0, cur}) - $signed({1'b0, stp});
    return (dn_diff <= $signed({1'b0, tgt})) ? tgt : dn_diff[W-1:0];
  endfunction

  assign next_o = sat_step(current_i, target_i, step_i);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the PWM duty toward a commanded target, one step every (interval+1) period ends.
// Define PWM_RAMP_RETARGET_EN to accept new commands while a ramp is running.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_CYCLE_WIDTH = DUTY_W_DEFAULT,
  parameter int INTERVAL_WIDTH   = 16,
  parameter int DEFAULT_DUTY     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [DUTY_CYCLE_WIDTH-1:0] cmd_target,
  input  logic [DUTY_CYCLE_WIDTH-1:0] cmd_step,
  input  logic [INTERVAL_WIDTH-1:0]   cmd_interval,
  input  logic                        period_end,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_out,
  output logic                        duty_load,
  output logic                        busy,
  output logic                        done
);

  localparam int W = DUTY_CYCLE_WIDTH;
  localparam logic [W-1:0] DUTY_RST = W'(DEFAULT_DUTY);

  ramp_state_e               state_q, state_d;
  logic [W-1:0]              duty_q, duty_d;
  logic [W-1:0]              target_q, target_d;
  logic [W-1:0]              step_q, step_d;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
  logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
  logic                      load_q, load_d;
  logic                      done_q, done_d;
  logic [W-1:0]              step_next;
  logic                      accept;
  logic                      step_fire;
  logic                      same_target;

  pwm_ramp_step #(
    .DUTY_CYCLE_WIDTH(W)
  ) u_step (
    .current_i(duty_q),
    .target_i (target_q),
    .step_i   (step_q),
    .next_o   (step_next)
  );

  assign accept      = cmd_valid && cmd_ready;
  assign same_target = (cmd_target == duty_q);
  // A command accepted on the same edge as a step wins; the step is dropped.
  assign step_fire   = (state_q == RAMP) && period_end && (cnt_q == interval_q) && !accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = same_target ? IDLE : RAMP;
    end else if (step_fire && (step_next == target_q)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy = (state_q == RAMP);
`ifdef PWM_RAMP_RETARGET_EN
    cmd_ready = 1'b1;
`else
    cmd_ready = (state_q == IDLE);
`endif
  end

  always_comb begin
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    cnt_d      = cnt_q;
    load_d     = 1'b0;
    done_d     = 1'b0;
    if (accept) begin
      target_d   = cmd_target;
      step_d     = cmd_step;
      interval_d = cmd_interval;
      cnt_d      = '0;
      done_d     = same_target;
    end else if ((state_q == RAMP) && period_end) begin
      if (step_fire) begin
        cnt_d  = '0;
        duty_d = step_next;
        load_d = 1'b1;
        done_d = (step_next == target_q);
      end else begin
        cnt_d = cnt_q + INTERVAL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q     <= DUTY_RST;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      done_q     <= done_d;
    end
  end

  assign duty_out  = duty_q;
  assign duty_load = load_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed and randomized ramps checked against an arithmetic reference of the duty sequence.
module tb_pwm_ramp_ctrl;

  localparam int W  = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_target = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [IW-1:0] cmd_interval = '0;
  logic          period_end = 1'b0;
  logic [W-1:0]  duty_out;
  logic          duty_load;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int model_duty = 0;

  pwm_ramp_ctrl #(
    .DUTY_CYCLE_WIDTH(W),
    .INTERVAL_WIDTH  (IW),
    .DEFAULT_DUTY    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_interval(cmd_interval),
    .period_end  (period_end),
    .duty_out    (duty_out),
    .duty_load   (duty_load),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: move toward target by step (0 = jump), never past it.
  function automatic int model_next(input int d, input int t, input int s);
    if (s == 0) return t;
    if (t > d) return (d + s > t) ? t : d + s;
    return (d - s < t) ? t : d - s;
  endfunction

  task automatic start_ramp(input int t, input int s, input int iv);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid    = 1'b1;
    cmd_target   = t[W-1:0];
    cmd_step     = s[W-1:0];
    cmd_interval = iv[IW-1:0];
    period_end   = 1'($urandom_range(0, 1));
    tick();
    cmd_valid  = 1'b0;
    period_end = 1'b0;
    if (t == model_duty) begin
      check("equal_done", 32'(done), 32'd1);
      check("equal_load", 32'(duty_load), 32'd0);
      check("equal_busy", 32'(busy), 32'd0);
      tick();
      check("equal_done_clear", 32'(done), 32'd0);
      check("equal_load_after", 32'(duty_load), 32'd0);
      check("equal_duty", 32'(duty_out), 32'(model_duty));
    end else begin
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_load", 32'(duty_load), 32'd0);
      check("accept_duty", 32'(duty_out), 32'(model_duty));
    end
  endtask

  // Drives period_end pulses; a step is due on every (iv+1)-th pulse after acceptance.
  task automatic pe_loop(input int t, input int s, input int iv, input int gap);
    int pe = 0;
    int guard = 0;
    int g;
    while (model_duty != t && guard < 2000) begin
      guard++;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        tick();
        check("hold_load", 32'(duty_load), 32'd0);
        check("hold_duty", 32'(duty_out), 32'(model_duty));
      end
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
      pe++;
      if (pe % (iv + 1) == 0) begin
        model_duty = model_next(model_duty, t, s);
        check("step_load", 32'(duty_load), 32'd1);
        check("step_duty", 32'(duty_out), 32'(model_duty));
        check("step_done", 32'(done), 32'(model_duty == t));
      end else begin
        check("wait_load", 32'(duty_load), 32'd0);
        check("wait_duty", 32'(duty_out), 32'(model_duty));
      end
    end
    check("ramp_bound", 32'(model_duty), 32'(t));
    check("end_busy", 32'(busy), 32'd0);
    tick();
    check("after_done", 32'(done), 32'd0);
    check("after_load", 32'(duty_load), 32'd0);
  endtask

  task automatic run_ramp(input int t, input int s, input int iv, input int gap);
    bit eq;
    eq = (t == model_duty);
    start_ramp(t, s, iv);
    if (!eq) pe_loop(t, s, iv, gap);
  endtask

  initial begin
    int t;
    int s;
    int iv;

    rst = 1'b0;
    repeat (3) tick();
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_load", 32'(duty_load), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();
    model_duty = 0;

    // 0 -> 200 in steps of 50, period_end every 10 clocks
    run_ramp(200, 50, 0, 9);
    // 200 -> 10 by 64, step every 2nd period_end
    run_ramp(10, 64, 1, -1);
    run_ramp(250, 0, 0, -1);
    // clamp at full scale
    run_ramp(255, 16, 0, -1);
    run_ramp(255, 5, 0, -1);
    run_ramp(77, 0, 2, -1);

    // asynchronous reset in the middle of a ramp
    run_ramp(0, 0, 0, -1);
    start_ramp(200, 50, 0);
    repeat (2) begin
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
      model_duty = model_next(model_duty, 200, 50);
      check("pre_rst_duty", 32'(duty_out), 32'(model_duty));
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_duty", 32'(duty_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_load", 32'(duty_load), 32'd0);
    tick();
    rst = 1'b1;
    model_duty = 0;
    repeat (3) begin
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
      check("postrst_load", 32'(duty_load), 32'd0);
      check("postrst_duty", 32'(duty_out), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end

    // command presented while a ramp is running
    start_ramp(100, 20, 0);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    model_duty = model_next(model_duty, 100, 20);
    check("pre_retarget_duty", 32'(duty_out), 32'(model_duty));
    cmd_valid    = 1'b1;
    cmd_target   = 8'd150;
    cmd_step     = 8'd30;
    cmd_interval = '0;
`ifdef PWM_RAMP_RETARGET_EN
    check("ramp_ready", 32'(cmd_ready), 32'd1);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    cmd_valid  = 1'b0;
    check("retarget_load", 32'(duty_load), 32'd0);
    check("retarget_duty", 32'(duty_out), 32'(model_duty));
    check("retarget_busy", 32'(busy), 32'd1);
    pe_loop(150, 30, 0, -1);
`else
    check("ramp_ready", 32'(cmd_ready), 32'd0);
    pe_loop(100, 20, 0, -1);
    cmd_valid = 1'b0;
    check("held_cmd_busy", 32'(busy), 32'd1);
    check("held_cmd_duty", 32'(duty_out), 32'(model_duty));
    pe_loop(150, 30, 0, -1);
`endif

    // randomized ramps
    repeat (15) begin
      t  = int'($urandom_range(0, 255));
      s  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, 255));
      iv = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) t = model_duty;
      run_ramp(t, s, iv, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
